// File: rtl/trig_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : trig_pulse_gen
//  Purpose  : Edge-triggered pulse generator. An asynchronous START input is
//             synchronised and edge-detected. Each accepted trigger produces
//             an optional delay followed by a pulse of programmable width.
//             Triggers that cannot be serviced are reported and counted.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    i_start      in   trigger request, asynchronous to clk
//    i_edge_mode  in   00 rise, 01 fall, 10 both, 11 disabled
//    i_pulse_len  in   pulse width in cycles (0 = ignore trigger)
//    i_pulse_dly  in   cycles from trigger to pulse start
//    i_retrig     in   1 = trigger during pulse restarts length count
//    o_pulse      out  registered output pulse
//    o_busy       out  high while not idle
//    o_done       out  one-cycle strobe after each completed pulse
//    o_missed     out  one-cycle strobe for each dropped trigger
//    o_miss_cnt   out  saturating dropped-trigger count
// ============================================================================
module trig_pulse_gen #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_edge_mode,
  input  logic [CNT_W-1:0] i_pulse_len,
  input  logic [CNT_W-1:0] i_pulse_dly,
  input  logic             i_retrig,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_missed,
  output logic [7:0]       o_miss_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DELAY  = 2'b01,
    S_ACTIVE = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] c_one      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_zero     = '0;
  localparam logic [2:0]       c_arm_done = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [2:0]             r_arm;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_len;
  logic                   r_pulse;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_missed;
  logic [7:0]             r_miss_cnt;

  logic                   w_s_sync;
  logic                   w_edge;
  logic                   w_armed;
  logic                   w_trig;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_len_nxt;
  logic                   w_missed;

  // Synchroniser, edge-detect history and arm counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_arm  <= 3'd0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_start};
      r_prev <= w_s_sync;
      if (r_arm != c_arm_done) begin
        r_arm <= r_arm + 3'd1;
      end
    end
  end

  assign w_s_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_edge = 1'b0;
    case (i_edge_mode)
      2'b00:   w_edge = w_s_sync & ~r_prev;
      2'b01:   w_edge = ~w_s_sync & r_prev;
      2'b10:   w_edge = w_s_sync ^ r_prev;
      default: w_edge = 1'b0;
    endcase
  end

  // A START level present at reset release would otherwise look like an
  // edge once it propagates through the synchroniser; hold off until then.
  assign w_armed = (r_arm == c_arm_done);
  assign w_trig  = w_edge & w_armed;

  // r_cnt holds the number of cycles remaining after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_missed    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig && (i_pulse_len != c_zero)) begin
          w_len_nxt = i_pulse_len;
          if (i_pulse_dly != c_zero) begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = i_pulse_dly - c_one;
          end else begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = i_pulse_len - c_one;
          end
        end
      end
      S_DELAY: begin
        w_missed = w_trig;
        if (r_cnt == c_zero) begin
          w_state_nxt = S_ACTIVE;
          w_cnt_nxt   = r_len - c_one;
        end else begin
          w_cnt_nxt = r_cnt - c_one;
        end
      end
      S_ACTIVE: begin
        if (w_trig && i_retrig && (i_pulse_len != c_zero)) begin
          // Retrigger: full new length counted from this edge
          w_len_nxt = i_pulse_len;
          w_cnt_nxt = i_pulse_len - c_one;
        end else begin
          w_missed = w_trig & ~i_retrig;
          if (r_cnt == c_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_cnt_nxt = r_cnt - c_one;
          end
        end
      end
      default: begin
        w_missed    = w_trig;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_missed   <= 1'b0;
      r_miss_cnt <= 8'd0;
    end else begin
      r_pulse  <= (w_state_nxt == S_ACTIVE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
      r_missed <= w_missed;
      if (w_missed && (r_miss_cnt != 8'hFF)) begin
        r_miss_cnt <= r_miss_cnt + 8'd1;
      end
    end
  end

  assign o_pulse    = r_pulse;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_missed   = r_missed;
  assign o_miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trig_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trig_pulse_gen
//  Purpose  : Self-checking bench for trig_pulse_gen. Stimulus pushes each
//             expected pulse (start cycle, width) into a queue; a monitor
//             measures every pulse the DUT produces and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trig_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start;
  logic [1:0] i_edge_mode;
  logic [7:0] i_pulse_len;
  logic [7:0] i_pulse_dly;
  logic       i_retrig;
  logic       o_pulse;
  logic       o_busy;
  logic       o_done;
  logic       o_missed;
  logic [7:0] o_miss_cnt;

  trig_pulse_gen #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_edge_mode (i_edge_mode),
    .i_pulse_len (i_pulse_len),
    .i_pulse_dly (i_pulse_dly),
    .i_retrig    (i_retrig),
    .o_pulse     (o_pulse),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_missed    (o_missed),
    .o_miss_cnt  (o_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int width;
  } exp_t;

  exp_t exp_q[$];
  int   cyc           = 0;
  int   checks        = 0;
  int   errors        = 0;
  int   miss_seen     = 0;
  int   pulse_start   = 0;
  bit   prev_pulse    = 1'b0;
  bit   abort_pending = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int start, input int width);
    exp_t e;
    e.start = start;
    e.width = width;
    exp_q.push_back(e);
  endtask

  // Monitor: measures each pulse and compares with the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (o_missed) miss_seen++;
    if (o_pulse && !prev_pulse) pulse_start = cyc;
    if (!o_pulse && prev_pulse) begin
      if (abort_pending) begin
        abort_pending = 1'b0;
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got start %0d width %0d expected none",
                 pulse_start, cyc - pulse_start);
      end else begin
        e = exp_q.pop_front();
        check("pulse_start", pulse_start, e.start);
        check("pulse_width", cyc - pulse_start, e.width);
        check("done_after_pulse", int'(o_done), 1);
        check("busy_in_done", int'(o_busy), 1);
      end
    end else if (o_done) begin
      checks++;
      errors++;
      $display("FAIL stray_done: got done=1 expected 0 (cycle %0d)", cyc);
    end
    prev_pulse = o_pulse;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m0;
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_edge_mode = 2'b00;
    i_pulse_len = 8'd8;
    i_pulse_dly = 8'd0;
    i_retrig    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(o_pulse), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_missed", int'(o_missed), 0);
    check("rst_miss_cnt", int'(o_miss_cnt), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Rising edge, len 8, no delay
    @(negedge clk); i_start = 1'b1; push(cyc + 3, 8);
    repeat (20) @(negedge clk);
    check("v1_busy_idle", int'(o_busy), 0);

    // Falling edge, len 4, delay 3; inputs changed mid-run must not matter
    i_edge_mode = 2'b01; i_pulse_len = 8'd4; i_pulse_dly = 8'd3;
    @(negedge clk); i_start = 1'b0; push(cyc + 6, 4);
    repeat (4) @(negedge clk);
    i_pulse_len = 8'd2; i_pulse_dly = 8'd1;
    repeat (16) @(negedge clk);
    check("v2_busy_idle", int'(o_busy), 0);
    check("v2_miss_cnt", int'(o_miss_cnt), 0);

    // Retrigger after three pulse cycles extends to 3+6
    i_edge_mode = 2'b00; i_pulse_len = 8'd6; i_pulse_dly = 8'd0; i_retrig = 1'b1;
    m0 = miss_seen;
    @(negedge clk); i_start = 1'b1; push(cyc + 3, 9);
    @(negedge clk); i_start = 1'b0;
    repeat (2) @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (16) @(negedge clk);
    check("v3_retrig_missed", miss_seen - m0, 0);
    check("v3_retrig_miss_cnt", int'(o_miss_cnt), 0);

    // Same stimulus without retrigger: one drop
    i_retrig = 1'b0;
    m0 = miss_seen;
    @(negedge clk); i_start = 1'b1; push(cyc + 3, 6);
    @(negedge clk); i_start = 1'b0;
    repeat (2) @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (16) @(negedge clk);
    check("v3_noretrig_missed", miss_seen - m0, 1);
    check("v3_noretrig_miss_cnt", int'(o_miss_cnt), 1);

    // Zero length: ignored, not counted
    i_pulse_len = 8'd0;
    m0 = miss_seen;
    @(negedge clk); i_start = 1'b1;
    repeat (10) @(negedge clk);
    check("v4_len0_busy", int'(o_busy), 0);
    check("v4_len0_missed", miss_seen - m0, 0);
    check("v4_len0_miss_cnt", int'(o_miss_cnt), 1);

    // Triggering disabled
    i_pulse_len = 8'd8; i_edge_mode = 2'b11;
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk); i_start = 1'b1;
    repeat (10) @(negedge clk);
    check("v4_mode11_busy", int'(o_busy), 0);
    check("v4_mode11_missed", miss_seen - m0, 0);

    // START held high through reset release must not trigger
    i_edge_mode = 2'b00;
    @(negedge clk); rst_n = 1'b0;
    #1 check("v4_rst_miss_cnt", int'(o_miss_cnt), 0);
    repeat (3) @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("v4_held_busy", int'(o_busy), 0);

    // 300 dropped triggers during a long delay+pulse, both-edge mode
    i_edge_mode = 2'b11;
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_edge_mode = 2'b10; i_pulse_len = 8'd255; i_pulse_dly = 8'd255;
    m0 = miss_seen;
    @(negedge clk); i_start = 1'b1; push(cyc + 258, 255);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); i_start = ~i_start;
    end
    repeat (5) @(negedge clk);
    check("v5_miss_sat", int'(o_miss_cnt), 255);
    check("v5_missed_strobes", miss_seen - m0, 300);
    i_edge_mode = 2'b00;
    repeat (220) @(negedge clk);
    check("v5_busy_idle", int'(o_busy), 0);
    check("v5_miss_hold", int'(o_miss_cnt), 255);

    // Reset asserted mid-pulse
    i_pulse_len = 8'd20; i_pulse_dly = 8'd0;
    @(negedge clk); i_start = 1'b0;
    @(negedge clk); i_start = 1'b1;
    repeat (8) @(negedge clk);
    check("v5_mid_pulse", int'(o_pulse), 1);
    abort_pending = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("v5_async_pulse", int'(o_pulse), 0);
    check("v5_async_busy", int'(o_busy), 0);
    check("v5_async_done", int'(o_done), 0);
    check("v5_async_miss_cnt", int'(o_miss_cnt), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("v5_after_rst_busy", int'(o_busy), 0);
    check("v5_abort_seen", int'(abort_pending), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
